vec_elem_sequencer: RTL and testbench
=====================================

Name: vec_elem_sequencer

Overview:
Element-issue stage for the vector datapath. Accepts one vector command (vector length) through a valid/ready handshake and emits element indices 0..vl-1 one per accepted beat to the lane. It then reports completion (element count, abort flag) through a second handshake. It replaces the free-running element counter with flow control, a last-element marker, clamping and abort.

Parameters:
IDX_WIDTH, 4, width of element index
MAX_VL, 2**IDX_WIDTH, largest legal vector length; must satisfy 1 <= MAX_VL <= 2**IDX_WIDTH

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (asserted when 0)
start_valid  input  1  command present
start_ready  output  1  sequencer can accept command
start_vl  input  IDX_WIDTH+1  requested vector length
abort  input  1  terminate current command early
elem_valid  output  1  element index presented
elem_ready  input  1  lane accepts element
elem_idx  output  IDX_WIDTH  current element index
elem_last  output  1  current element is final one
done_valid  output  1  completion record present
done_ready  input  1  consumer accepts completion
done_count  output  IDX_WIDTH+1  elements accepted by lane for this command
done_aborted  output  1  command ended by abort
done_clamped  output  1  start_vl exceeded MAX_VL and was clamped
busy  output  1  state != IDLE

Behaviour:
- Reset (reset==0 at a rising edge): state=IDLE, idx=0, vl_q=0, count=0, flags=0. All outputs are 0 except start_ready=1. Reset mid-command discards the command; no done record is produced.
- FSM states: IDLE, ISSUE, DONE. Outputs are Moore (registered state/idx only). There is no combinational path from the ready inputs to the valid outputs.
- IDLE:
  - start_ready=1.
  - Handshake (start_valid & start_ready) latches vl_q = min(start_vl, MAX_VL) and done_clamped = (start_vl > MAX_VL); it clears idx, count and done_aborted.
  - If latched vl_q == 0: next=DONE with count 0. Otherwise next=ISSUE.
  - abort in IDLE is ignored.
- ISSUE:
  - elem_valid=1, elem_idx=idx, elem_last=(idx == vl_q-1). start_ready=0.
  - Beat = elem_valid & elem_ready. On a beat: count+1.
  - On a beat with elem_last=1: next=DONE. On a beat without elem_last: idx+1, stay.
  - elem_idx is held stable while elem_valid & !elem_ready.
  - abort=1 in ISSUE: next=DONE, done_aborted=1. If a beat occurs in the same cycle, that beat counts first (count includes it).
  - abort together with the last beat: done_aborted=0, because the command completed normally.
- DONE:
  - done_valid=1 with done_count/done_aborted/done_clamped stable until done_ready.
  - On done_ready: next=IDLE, and start_ready is 1 from the following cycle (no start accepted in the DONE cycle).
- Latency:
  - Start handshake at cycle N gives elem_valid at N+1.
  - The last beat at cycle M gives done_valid at M+1.
  - The done handshake at cycle K gives start_ready at K+1.
  - Minimum command period is vl+2 cycles with elem_ready tied high.
- Width rules: idx never exceeds vl_q-1, so there is no index wrap. count ranges 0..MAX_VL and fits IDX_WIDTH+1 bits. The clamp compares at full IDX_WIDTH+1 width.

Optional Feature:
Macro SEQ_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles [15:0], which counts cycles in ISSUE with elem_valid & !elem_ready.
  - Saturates at 16'hFFFF.
  - Cleared on reset and on each start handshake.
  - Value is frozen and readable while in DONE and IDLE.
- Not defined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Basic issue: start_vl=5, elem_ready=1 -> elem_idx 0,1,2,3,4 on consecutive cycles, elem_last only on idx 4. Then done_valid with done_count=5, aborted=0, clamped=0.
- Backpressure: start_vl=3, elem_ready low for 2 cycles at idx 1 -> idx 1 held 3 cycles. done_count=3. With SEQ_STALL_CNT_EN, stall_cycles=2.
- Zero length and clamp:
  - start_vl=0 -> no elem_valid; done_valid next cycle, done_count=0.
  - start_vl=20 (IDX_WIDTH=4, MAX_VL=16) -> 16 elements, done_clamped=1, done_count=16.
- Abort:
  - start_vl=8, abort during the idx 3 beat -> done_count=4, done_aborted=1.
  - Abort coincident with the last beat -> done_count=8, done_aborted=0.
- Done backpressure: hold done_ready=0 for 4 cycles -> done fields stable and start_ready=0. After done_ready, start_ready=1 the next cycle.
- Reset mid-command: reset=0 during ISSUE at idx 2 -> next cycle busy=0, elem_valid=0, start_ready=1, and no done_valid.

Source files
------------

// File: rtl/vec_elem_sequencer.sv
// ---------------------------------------------------------------------------
// vec_elem_sequencer
//
// Purpose:
//   Element-issue stage for the vector datapath. Takes one vector command
//   (a vector length) through a valid/ready handshake. It then issues element
//   indices 0..vl-1 to the lane, one per accepted beat. Finally it reports a
//   completion record (count, aborted, clamped) through a second handshake.
//   All outputs are Moore outputs decoded from registered state, so there is
//   no combinational path from the ready inputs to the valid outputs.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-low reset
//   start_valid   command present            start_ready   can accept command
//   start_vl      requested vector length    abort         end command early
//   elem_valid    element presented          elem_ready    lane accepts element
//   elem_idx      current element index      elem_last     final element
//   done_valid    completion present         done_ready    consumer accepts
//   done_count    elements accepted by lane  done_aborted  ended by abort
//   done_clamped  start_vl exceeded MAX_VL   busy          not idle
//   stall_cycles  (SEQ_STALL_CNT_EN only) saturating count of ISSUE stalls
//
// Configuration:
//   `define SEQ_STALL_CNT_EN adds the stall_cycles output and its counter.
// ---------------------------------------------------------------------------
module vec_elem_sequencer #(
    parameter int IDX_WIDTH = 4,
    parameter int MAX_VL    = 2 ** IDX_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [IDX_WIDTH:0]   start_vl,
    input  logic                 abort,
    output logic                 elem_valid,
    input  logic                 elem_ready,
    output logic [IDX_WIDTH-1:0] elem_idx,
    output logic                 elem_last,
    output logic                 done_valid,
    input  logic                 done_ready,
    output logic [IDX_WIDTH:0]   done_count,
    output logic                 done_aborted,
    output logic                 done_clamped,
`ifdef SEQ_STALL_CNT_EN
    output logic [15:0]          stall_cycles,
`endif
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [IDX_WIDTH:0] MAX_VL_W = (IDX_WIDTH + 1)'(MAX_VL);
    localparam logic [IDX_WIDTH:0] ONE_W    = (IDX_WIDTH + 1)'(1);

    state_t                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [IDX_WIDTH:0]     vl_q, vl_d;
    logic [IDX_WIDTH:0]     count_q, count_d;
    logic                   aborted_q, aborted_d;
    logic                   clamped_q, clamped_d;
    logic                   last_w;
    logic                   beat_w;
`ifdef SEQ_STALL_CNT_EN
    logic [15:0]            stall_q, stall_d;
`endif

    // idx is widened by one bit so the compare against vl_q-1 is at full
    // width; vl_q is never 0 while in ISSUE, so the subtraction cannot wrap.
    assign last_w = (state_q == ISSUE) && ({1'b0, idx_q} == (vl_q - ONE_W));
    assign beat_w = (state_q == ISSUE) && elem_ready;

    // Moore output decode from the registered state and datapath.
    always_comb begin
        start_ready  = (state_q == IDLE);
        elem_valid   = (state_q == ISSUE);
        elem_idx     = idx_q;
        elem_last    = last_w;
        done_valid   = (state_q == DONE);
        done_count   = count_q;
        done_aborted = aborted_q;
        done_clamped = clamped_q;
        busy         = (state_q != IDLE);
    end

`ifdef SEQ_STALL_CNT_EN
    assign stall_cycles = stall_q;
`endif

    // Next-state and datapath update. Defaults hold every register.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        vl_d      = vl_q;
        count_d   = count_q;
        aborted_d = aborted_q;
        clamped_d = clamped_q;
`ifdef SEQ_STALL_CNT_EN
        stall_d   = stall_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    clamped_d = (start_vl > MAX_VL_W);
                    vl_d      = (start_vl > MAX_VL_W) ? MAX_VL_W : start_vl;
                    idx_d     = '0;
                    count_d   = '0;
                    aborted_d = 1'b0;
`ifdef SEQ_STALL_CNT_EN
                    stall_d   = '0;
`endif
                    // A zero-length command skips straight to reporting.
                    state_d   = (start_vl == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
`ifdef SEQ_STALL_CNT_EN
                if (!elem_ready && (stall_q != 16'hFFFF)) begin
                    stall_d = stall_q + 16'd1;
                end
`endif
                if (beat_w) begin
                    count_d = count_q + ONE_W;
                end
                // A last beat completes normally even if abort is also high;
                // otherwise abort wins, after any same-cycle beat has counted.
                if (beat_w && last_w) begin
                    state_d = DONE;
                end else if (abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else if (beat_w) begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            vl_q      <= '0;
            count_q   <= '0;
            aborted_q <= 1'b0;
            clamped_q <= 1'b0;
`ifdef SEQ_STALL_CNT_EN
            stall_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            vl_q      <= vl_d;
            count_q   <= count_d;
            aborted_q <= aborted_d;
            clamped_q <= clamped_d;
`ifdef SEQ_STALL_CNT_EN
            stall_q   <= stall_d;
`endif
        end
    end

endmodule

// File: tb/tb_vec_elem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vec_elem_sequencer
//
// Self-checking bench for vec_elem_sequencer (IDX_WIDTH=4, MAX_VL=16).
// The reference model is transaction level. For each command it tracks how
// many elements the lane has accepted. From that count and the chosen
// ready/abort pattern it derives the expected index, last marker, completion
// record and stall count.
// Honours SEQ_STALL_CNT_EN so the same bench covers both builds.
// ---------------------------------------------------------------------------
module tb_vec_elem_sequencer;

    localparam int IDX_WIDTH = 4;
    localparam int MAX_VL    = 16;

    logic                 clk;
    logic                 reset;
    logic                 start_valid;
    logic                 start_ready;
    logic [IDX_WIDTH:0]   start_vl;
    logic                 abort;
    logic                 elem_valid;
    logic                 elem_ready;
    logic [IDX_WIDTH-1:0] elem_idx;
    logic                 elem_last;
    logic                 done_valid;
    logic                 done_ready;
    logic [IDX_WIDTH:0]   done_count;
    logic                 done_aborted;
    logic                 done_clamped;
    logic                 busy;
`ifdef SEQ_STALL_CNT_EN
    logic [15:0]          stall_cycles;
`endif

    int vectors;
    int miscompares;

    vec_elem_sequencer #(
        .IDX_WIDTH(IDX_WIDTH),
        .MAX_VL   (MAX_VL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_vl    (start_vl),
        .abort       (abort),
        .elem_valid  (elem_valid),
        .elem_ready  (elem_ready),
        .elem_idx    (elem_idx),
        .elem_last   (elem_last),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .done_count  (done_count),
        .done_aborted(done_aborted),
        .done_clamped(done_clamped),
`ifdef SEQ_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .busy        (busy)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one cycle and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one full command: start handshake, element issue, then completion.
    // randStall: random lane backpressure. Otherwise the lane stalls for
    // stallLen cycles while element stallIdx is presented.
    // abortIdx: abort is driven while that element index is presented
    // (-1 for never). doneHold: cycles done_ready is held low.
    task automatic applyStimulus(input int vl, input bit randStall, input int stallIdx,
                                 input int stallLen, input int abortIdx, input int doneHold);
        int vlEff, issued, stallLeft, stalls, cycles;
        bit finished, expAborted, expClamped, rdy, abt, last;
        vlEff      = (vl > MAX_VL) ? MAX_VL : vl;
        expClamped = (vl > MAX_VL);
        issued     = 0;
        stallLeft  = stallLen;
        stalls     = 0;
        cycles     = 0;
        finished   = (vlEff == 0);
        expAborted = 1'b0;

        checkOutput("start_ready_idle", start_ready, 1);
        start_valid = 1'b1;
        start_vl    = 5'(vl);
        tick();
        start_valid = 1'b0;

        while (!finished) begin
            if (cycles >= 400) begin
                checkOutput("issue_cycle_budget", cycles, 0);
                break;
            end
            last = (issued == vlEff - 1);
            checkOutput("elem_valid", elem_valid, 1);
            checkOutput("elem_idx", elem_idx, issued);
            checkOutput("elem_last", elem_last, last);
            checkOutput("start_ready_issue", start_ready, 0);
            checkOutput("done_valid_issue", done_valid, 0);
            if (randStall) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else if (issued == stallIdx && stallLeft > 0) begin
                rdy = 1'b0;
                stallLeft--;
            end else begin
                rdy = 1'b1;
            end
            abt        = (issued == abortIdx);
            elem_ready = rdy;
            abort      = abt;
            if (!rdy) stalls++;
            tick();
            cycles++;
            if (rdy) issued++;
            if (rdy && last) begin
                finished = 1'b1;
            end else if (abt) begin
                finished   = 1'b1;
                expAborted = 1'b1;
            end
        end
        elem_ready = 1'b0;
        abort      = 1'b0;

        for (int h = 0; h <= doneHold; h++) begin
            checkOutput("done_valid", done_valid, 1);
            checkOutput("done_count", done_count, issued);
            checkOutput("done_aborted", done_aborted, expAborted);
            checkOutput("done_clamped", done_clamped, expClamped);
            checkOutput("start_ready_done", start_ready, 0);
            checkOutput("elem_valid_done", elem_valid, 0);
            checkOutput("busy_done", busy, 1);
`ifdef SEQ_STALL_CNT_EN
            checkOutput("stall_cycles_done", stall_cycles, stalls);
`endif
            if (h == doneHold) begin
                done_ready  = 1'b1;
                start_valid = 1'b0;
            end else begin
                // A start offered during DONE must be ignored.
                done_ready  = 1'b0;
                start_valid = 1'($urandom_range(0, 1));
                start_vl    = 5'($urandom_range(1, 20));
            end
            tick();
        end
        done_ready  = 1'b0;
        start_valid = 1'b0;

        checkOutput("start_ready_after", start_ready, 1);
        checkOutput("done_valid_after", done_valid, 0);
        checkOutput("busy_after", busy, 0);
        checkOutput("elem_valid_after", elem_valid, 0);
`ifdef SEQ_STALL_CNT_EN
        checkOutput("stall_cycles_idle", stall_cycles, stalls);
`endif
    endtask

    initial begin
        int vl, abortIdx;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        start_valid = 1'b0;
        start_vl    = '0;
        abort       = 1'b0;
        elem_ready  = 1'b0;
        done_ready  = 1'b0;
        tick();
        tick();

        // Reset state.
        checkOutput("rst_start_ready", start_ready, 1);
        checkOutput("rst_elem_valid", elem_valid, 0);
        checkOutput("rst_elem_idx", elem_idx, 0);
        checkOutput("rst_elem_last", elem_last, 0);
        checkOutput("rst_done_valid", done_valid, 0);
        checkOutput("rst_done_count", done_count, 0);
        checkOutput("rst_done_aborted", done_aborted, 0);
        checkOutput("rst_done_clamped", done_clamped, 0);
        checkOutput("rst_busy", busy, 0);
`ifdef SEQ_STALL_CNT_EN
        checkOutput("rst_stall_cycles", stall_cycles, 0);
`endif
        reset = 1'b1;
        tick();

        // Directed cases.
        applyStimulus(5, 1'b0, -1, 0, -1, 0);   // basic issue
        applyStimulus(3, 1'b0, 1, 2, -1, 0);    // backpressure at idx 1
        applyStimulus(0, 1'b0, -1, 0, -1, 0);   // zero length
        applyStimulus(20, 1'b0, -1, 0, -1, 0);  // clamp to 16
        applyStimulus(8, 1'b0, -1, 0, 3, 0);    // abort on idx 3 beat
        applyStimulus(8, 1'b0, -1, 0, 7, 0);    // abort with last beat
        applyStimulus(8, 1'b0, 2, 3, 2, 0);     // abort while stalled
        applyStimulus(4, 1'b0, -1, 0, -1, 4);   // done backpressure
        applyStimulus(16, 1'b0, -1, 0, -1, 0);  // exactly MAX_VL
        applyStimulus(17, 1'b0, -1, 0, -1, 1);  // smallest clamp

        // Reset in the middle of a command.
        checkOutput("mid_start_ready", start_ready, 1);
        start_valid = 1'b1;
        start_vl    = 5'd8;
        tick();
        start_valid = 1'b0;
        elem_ready  = 1'b1;
        tick();
        tick();
        checkOutput("mid_elem_idx", elem_idx, 2);
        reset = 1'b0;
        tick();
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_elem_valid", elem_valid, 0);
        checkOutput("mid_rst_start_ready", start_ready, 1);
        checkOutput("mid_rst_done_valid", done_valid, 0);
`ifdef SEQ_STALL_CNT_EN
        checkOutput("mid_rst_stall", stall_cycles, 0);
`endif
        reset      = 1'b1;
        elem_ready = 1'b0;
        tick();
        checkOutput("mid_post_done_valid", done_valid, 0);
        checkOutput("mid_post_start_ready", start_ready, 1);

        // Randomized commands.
        for (int n = 0; n < 40; n++) begin
            vl       = $urandom_range(0, 20);
            abortIdx = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 16) : -1;
            applyStimulus(vl, 1'b1, -1, 0, abortIdx, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
